// File: rtl/regfile_sb.sv
// Integer register file with a per-register busy scoreboard for decode hazard stalls.
// Define REGFILE_BYPASS_EN to forward same-cycle writeback data to the read ports.
module regfile_sb #(
  parameter int unsigned     XLEN     = 32,
  parameter int unsigned     ADDR_W   = 4,
  parameter logic [XLEN-1:0] RST_DATA = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] rs1,
  input  logic [ADDR_W-1:0] rs2,
  output logic [XLEN-1:0]   src1,
  output logic [XLEN-1:0]   src2,
  output logic              rs1_busy,
  output logic              rs2_busy,
  input  logic              rsv_valid,
  input  logic [ADDR_W-1:0] rsv_rd,
  output logic              rsv_ready,
  input  logic              wb_valid,
  input  logic [ADDR_W-1:0] wb_rd,
  input  logic [XLEN-1:0]   wb_data,
  output logic [ADDR_W:0]   busy_cnt,
  output logic              wb_err
);

  localparam int unsigned NREG = 2**ADDR_W;

  logic [XLEN-1:0]   data_q [NREG];
  logic [NREG-1:0]   busy_q, busy_d;
  logic [ADDR_W:0]   cnt_q, cnt_d;
  logic              err_q, err_d;
  logic              wb_hit, rsv_acc, cnt_inc, cnt_dec;

  assign wb_hit    = wb_valid && (wb_rd != '0);
  // busy_q[0] is never set, so a reservation of x0 is always ready.
  assign rsv_ready = !busy_q[rsv_rd] || (wb_valid && (wb_rd == rsv_rd));
  assign rsv_acc   = rsv_valid && rsv_ready && (rsv_rd != '0);

  always_comb begin
    busy_d  = busy_q;
    err_d   = err_q;
    cnt_inc = rsv_acc && !busy_q[rsv_rd];
    cnt_dec = wb_hit && busy_q[wb_rd] && !(rsv_acc && (rsv_rd == wb_rd));
    if (wb_hit) begin
      if (!busy_q[wb_rd]) err_d = 1'b1;
      busy_d[wb_rd] = 1'b0;
    end
    // Applied after the clear so a same-cycle re-reservation wins.
    if (rsv_acc) busy_d[rsv_rd] = 1'b1;
    cnt_d = cnt_q;
    case ({cnt_inc, cnt_dec})
      2'b10:   cnt_d = cnt_q + (ADDR_W+1)'(1);
      2'b01:   cnt_d = cnt_q - (ADDR_W+1)'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned i = 0; i < NREG; i++) data_q[i] <= RST_DATA;
      busy_q <= '0;
      cnt_q  <= '0;
      err_q  <= 1'b0;
    end else begin
      if (wb_hit) data_q[wb_rd] <= wb_data;
      busy_q <= busy_d;
      cnt_q  <= cnt_d;
      err_q  <= err_d;
    end
  end

  assign busy_cnt = cnt_q;
  assign wb_err   = err_q;

  always_comb begin
    src1     = (rs1 == '0) ? '0 : data_q[rs1];
    rs1_busy = busy_q[rs1];
    src2     = (rs2 == '0) ? '0 : data_q[rs2];
    rs2_busy = busy_q[rs2];
`ifdef REGFILE_BYPASS_EN
    if (wb_hit && (wb_rd == rs1)) begin
      src1     = wb_data;
      rs1_busy = 1'b0;
    end
    if (wb_hit && (wb_rd == rs2)) begin
      src2     = wb_data;
      rs2_busy = 1'b0;
    end
`endif
  end

endmodule

// File: tb/tb_regfile_sb.sv
// Directed bench for regfile_sb: an RV32E instance (RST_DATA=0) and an RV32I
// instance with a nonzero reset value for the full-occupancy and reset cases.
module tb_regfile_sb;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_assert = 0;
  int n_fail   = 0;

  localparam logic [31:0] I_RST = 32'h0F0F_0000;

`ifdef REGFILE_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  // RV32E instance
  logic        e_rst, e_rsv_valid, e_rsv_ready, e_wb_valid, e_rs1_busy, e_rs2_busy, e_wb_err;
  logic [3:0]  e_rs1, e_rs2, e_rsv_rd, e_wb_rd;
  logic [31:0] e_src1, e_src2, e_wb_data;
  logic [4:0]  e_cnt;

  regfile_sb #(.XLEN(32), .ADDR_W(4), .RST_DATA(32'h0)) u_e (
    .clk(clk), .rst(e_rst), .rs1(e_rs1), .rs2(e_rs2), .src1(e_src1), .src2(e_src2),
    .rs1_busy(e_rs1_busy), .rs2_busy(e_rs2_busy), .rsv_valid(e_rsv_valid),
    .rsv_rd(e_rsv_rd), .rsv_ready(e_rsv_ready), .wb_valid(e_wb_valid), .wb_rd(e_wb_rd),
    .wb_data(e_wb_data), .busy_cnt(e_cnt), .wb_err(e_wb_err)
  );

  // RV32I instance
  logic        i_rst, i_rsv_valid, i_rsv_ready, i_wb_valid, i_rs1_busy, i_rs2_busy, i_wb_err;
  logic [4:0]  i_rs1, i_rs2, i_rsv_rd, i_wb_rd;
  logic [31:0] i_src1, i_src2, i_wb_data;
  logic [5:0]  i_cnt;

  regfile_sb #(.XLEN(32), .ADDR_W(5), .RST_DATA(I_RST)) u_i (
    .clk(clk), .rst(i_rst), .rs1(i_rs1), .rs2(i_rs2), .src1(i_src1), .src2(i_src2),
    .rs1_busy(i_rs1_busy), .rs2_busy(i_rs2_busy), .rsv_valid(i_rsv_valid),
    .rsv_rd(i_rsv_rd), .rsv_ready(i_rsv_ready), .wb_valid(i_wb_valid), .wb_rd(i_wb_rd),
    .wb_data(i_wb_data), .busy_cnt(i_cnt), .wb_err(i_wb_err)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    // ---------------- RV32E: reset with a writeback held active ----------------
    e_rst = 1'b1; e_rsv_valid = 1'b0; e_rsv_rd = '0; e_rs1 = '0; e_rs2 = '0;
    e_wb_valid = 1'b1; e_wb_rd = 4'd3; e_wb_data = 32'hAA;
    i_rst = 1'b1; i_rsv_valid = 1'b0; i_rsv_rd = '0; i_rs1 = '0; i_rs2 = '0;
    i_wb_valid = 1'b0; i_wb_rd = '0; i_wb_data = '0;
    #1;
    tick(); tick();
    e_rst = 1'b0; e_wb_valid = 1'b0;
    #1;
    for (int r = 0; r < 16; r++) begin
      e_rs1 = 4'(r); e_rs2 = 4'(15 - r);
      #1;
      check($sformatf("rst_src1_x%0d", r), e_src1, 0);
      check($sformatf("rst_src2_x%0d", 15 - r), e_src2, 0);
      check($sformatf("rst_busy1_x%0d", r), e_rs1_busy, 0);
    end
    check("rst_cnt", e_cnt, 0);
    check("rst_err", e_wb_err, 0);

    // ---------------- reserve x5, then writeback ----------------
    e_rsv_valid = 1'b1; e_rsv_rd = 4'd5; #1;
    check("rsv5_ready", e_rsv_ready, 1);
    tick();
    e_rsv_valid = 1'b0; e_rs1 = 4'd5; #1;
    check("rsv5_busy", e_rs1_busy, 1);
    check("rsv5_cnt", e_cnt, 1);
    e_wb_valid = 1'b1; e_wb_rd = 4'd5; e_wb_data = 32'hDEADBEEF; #1;
    check("wb5_same_src1", e_src1, BYP ? 32'hDEADBEEF : 32'h0);
    check("wb5_same_busy", e_rs1_busy, BYP ? 1'b0 : 1'b1);
    check("wb5_same_cnt", e_cnt, 1);
    tick();
    e_wb_valid = 1'b0; #1;
    check("wb5_src1", e_src1, 32'hDEADBEEF);
    check("wb5_busy", e_rs1_busy, 0);
    check("wb5_cnt", e_cnt, 0);
    check("wb5_err", e_wb_err, 0);

    // ---------------- double reserve x7, then wb+rsv same cycle ----------------
    e_rsv_valid = 1'b1; e_rsv_rd = 4'd7; #1;
    tick();
    check("rsv7_again_ready", e_rsv_ready, 0);
    tick();
    e_rs2 = 4'd7; #1;
    check("rsv7_cnt", e_cnt, 1);
    check("rsv7_busy", e_rs2_busy, 1);
    e_rsv_valid = 1'b0; #1;
    check("rsv7_ready_novalid", e_rsv_ready, 0);
    e_rsv_valid = 1'b1; e_wb_valid = 1'b1; e_wb_rd = 4'd7; e_wb_data = 32'h0000_0777; #1;
    check("wbrsv7_ready", e_rsv_ready, 1);
    tick();
    e_rsv_valid = 1'b0; e_wb_valid = 1'b0; #1;
    check("wbrsv7_src2", e_src2, 32'h777);
    check("wbrsv7_busy", e_rs2_busy, 1);
    check("wbrsv7_cnt", e_cnt, 1);
    check("wbrsv7_err", e_wb_err, 0);

    // ---------------- x0 targets ----------------
    e_rs1 = 4'd0; e_wb_valid = 1'b1; e_wb_rd = 4'd0; e_wb_data = 32'h1234;
    e_rsv_valid = 1'b1; e_rsv_rd = 4'd0; #1;
    check("x0_ready", e_rsv_ready, 1);
    check("x0_same_src1", e_src1, 0);
    tick();
    e_wb_valid = 1'b0; e_rsv_valid = 1'b0; #1;
    check("x0_src1", e_src1, 0);
    check("x0_busy", e_rs1_busy, 0);
    check("x0_cnt", e_cnt, 1);
    check("x0_err", e_wb_err, 0);

    // ---------------- writeback to an unreserved register ----------------
    e_wb_valid = 1'b1; e_wb_rd = 4'd9; e_wb_data = 32'h55; #1;
    tick();
    e_wb_valid = 1'b0; e_rs1 = 4'd9; #1;
    check("wb9_src1", e_src1, 32'h55);
    check("wb9_err", e_wb_err, 1);
    check("wb9_cnt", e_cnt, 1);
    e_wb_valid = 1'b1; e_wb_rd = 4'd7; e_wb_data = 32'h70; #1;
    tick();
    e_wb_valid = 1'b0; #1;
    check("wb7_cnt", e_cnt, 0);
    check("wb7_src2", e_src2, 32'h70);
    check("err_sticky", e_wb_err, 1);
    e_rst = 1'b1; e_rsv_valid = 1'b1; e_rsv_rd = 4'd2; #1;
    tick();
    e_rst = 1'b0; e_rsv_valid = 1'b0; e_rs2 = 4'd2; #1;
    check("rst2_err", e_wb_err, 0);
    check("rst2_src1_x9", e_src1, 0);
    check("rst2_busy_x2", e_rs2_busy, 0);
    check("rst2_cnt", e_cnt, 0);

    // ---------------- RV32I: reset value, full occupancy, mid-sequence reset ----------------
    i_rst = 1'b0; i_rs1 = 5'd31; i_rs2 = 5'd0; #1;
    check("i_rst_src1_x31", i_src1, I_RST);
    check("i_rst_src2_x0", i_src2, 0);
    for (int k = 1; k < 32; k++) begin
      i_rsv_valid = 1'b1; i_rsv_rd = 5'(k); #1;
      tick();
    end
    i_rsv_valid = 1'b0; #1;
    check("i_full_cnt", i_cnt, 31);
    check("i_full_busy31", i_rs1_busy, 1);
    check("i_full_ready31", i_rsv_ready, 0);
    i_rst = 1'b1; tick(); i_rst = 1'b0; #1;
    for (int k = 1; k <= 8; k++) begin
      i_rsv_valid = 1'b1; i_rsv_rd = 5'(k); #1;
      tick();
    end
    check("i_part_cnt", i_cnt, 8);
    i_rst = 1'b1; i_rsv_rd = 5'd9; #1;
    tick();
    i_rst = 1'b0; i_rsv_valid = 1'b0; #1;
    check("i_midrst_cnt", i_cnt, 0);
    for (int r = 0; r < 32; r++) begin
      i_rs1 = 5'(r); #1;
      check($sformatf("i_midrst_busy_x%0d", r), i_rs1_busy, 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/regfile_sb.md
# regfile_sb

Parametrised integer register file with an integrated busy-bit scoreboard, the successor to the fixed RV32E register file. It provides two asynchronous read ports and one synchronous writeback port, plus a one-per-cycle destination-reservation port. The decode stage uses the reservation port to stall on RAW/WAW hazards; writeback clears reservations. It sits between decode/issue and writeback in the npc core, and `NREG`=16 or 32 selects RV32E or RV32I.

## Interface
- `XLEN`, 32, data width of each register
- `ADDR_W`, 4, register index width; `NREG = 2**ADDR_W` (4 → RV32E, 5 → RV32I)
- `RST_DATA`, 0, reset value of registers 1..NREG-1
- `clk`  in  1  sole clock, rising edge
- `rst`  in  1  synchronous reset, active-high
- `rs1`, `rs2`  in  ADDR_W  read indices
- `src1`, `src2`  out  XLEN  read data (combinational)
- `rs1_busy`, `rs2_busy`  out  1  indexed register has an outstanding reservation
- `rsv_valid`  in  1  request to reserve `rsv_rd`
- `rsv_rd`  in  ADDR_W  destination to reserve
- `rsv_ready`  out  1  reservation accepted this cycle (combinational)
- `wb_valid`  in  1  writeback strobe
- `wb_rd`  in  ADDR_W  writeback index
- `wb_data`  in  XLEN  writeback data
- `busy_cnt`  out  ADDR_W+1  number of currently busy registers
- `wb_err`  out  1  sticky: a writeback hit a non-busy register (x0 excluded)

## Operation
- Storage: `NREG`×`XLEN` data array plus an `NREG`-bit busy vector.
- x0: reads return 0, is never busy, ignores writes and reservations; `rsv_rd`=0 → `rsv_ready`=1 with no state change; `wb_rd`=0 → no-op, no error.
- Read: `srcN` = data[`rsN`], `rsN_busy` = busy[`rsN`]; both reflect registered state (see Configuration for bypass).
- Writeback (`wb_valid`, `wb_rd`≠0): data[`wb_rd`] ← `wb_data` and busy[`wb_rd`] ← 0 at the next edge. If busy[`wb_rd`] was already 0, the write still occurs and `wb_err` is set to 1 and held until reset.
- Reservation: `rsv_ready` = !busy[`rsv_rd`] || (`wb_valid` && `wb_rd`==`rsv_rd`). When `rsv_valid` && `rsv_ready` and `rsv_rd`≠0, busy[`rsv_rd`] ← 1 at the next edge. A rejected request (`rsv_ready`=0) has no effect; the requester holds it and retries.
- Same-cycle wb and rsv to the same nonzero rd: data is written, busy ends at 1 (new reservation wins), and `busy_cnt` is unchanged.
- `busy_cnt` update: +1 on accepted reservation of a non-busy reg; −1 on wb of a busy reg that is not re-reserved that cycle; net 0 when both occur. It never exceeds `NREG`-1.

## Timing
- Reset: all data regs ← `RST_DATA`, busy ← 0, `busy_cnt` ← 0, `wb_err` ← 0. Reset has priority over wb/rsv in the same cycle, and mid-operation reset drops all reservations.
- Write latency is 1 cycle; written data is visible on `srcN` in the cycle after `wb_valid` (0 cycles with bypass).
- Busy set and clear each take effect 1 cycle after the accepting edge.
- `rsv_ready`, `srcN` and `rsN_busy` are purely combinational from inputs and state. There is no combinational path from `rsv_valid` to any output.

## Configuration
- `REGFILE_BYPASS_EN` defined: when `wb_valid` && `wb_rd`==`rsN` && `rsN`≠0, `srcN` = `wb_data` and `rsN_busy` = 0 in the same cycle, which gives zero-cycle writeback-to-read forwarding.
- Undefined: reads see only registered state. A read of `wb_rd` during the writeback cycle returns the old data with `rsN_busy`=1 if the register was reserved.

## Test plan
- Reset, then read all indices → every `srcN`=`RST_DATA`=0, `busy`=0, `busy_cnt`=0, `wb_err`=0; hold `wb_valid`=1, `wb_rd`=3, `wb_data`=0xAA during reset → x3 still 0 after reset.
- Reserve x5, check `rs1`=5 next cycle → `rs1_busy`=1, `busy_cnt`=1; then wb x5 with 0xDEADBEEF → next cycle `src1`=0xDEADBEEF, `rs1_busy`=0, `busy_cnt`=0; with the bypass macro, `src1`=0xDEADBEEF during the wb cycle itself.
- Reserve x7 twice with no wb → second request sees `rsv_ready`=0 and `busy_cnt` stays 1; then wb x7 and rsv x7 in the same cycle → `rsv_ready`=1, x7 is updated, busy stays 1, `busy_cnt`=1.
- Target x0: wb x0 with 0x1234 and rsv x0 → `src1`(rs1=0)=0, `rs1_busy`=0, `rsv_ready`=1, `busy_cnt` and `wb_err` unchanged.
- Wb x9 (not reserved) with 0x55 → x9=0x55 next cycle, `wb_err`=1 and it remains 1 through further traffic until `rst`.
- `ADDR_W`=5: reserve x1..x31 on consecutive cycles → `busy_cnt`=31; assert `rst` mid-sequence → the next cycle shows `busy_cnt`=0 and all busy bits clear.
